key_debounce_ctrl: RTL and testbench
====================================

// Module: key_debounce_ctrl
// PURPOSE
//  Per-key debouncer and event generator for the board push-buttons (button_in) feeding the top-level control logic.
//  Synchronises raw buttons, filters bounce with a shared 1 ms tick, and emits debounced levels.
//  Also emits one-cycle press, release and long-press pulses consumed by the mode/counter logic that drives seg/select.
// PARAMETERS
//  N_KEYS       3           number of buttons
//  CLK_FREQ_HZ  50_000_000  clk frequency; TICK_DIV = CLK_FREQ_HZ/1000 cycles per 1 ms tick (>=2)
//  DEBOUNCE_MS  20          ticks the synced input must differ continuously from the debounced level before it is accepted
//  LONG_MS      1000        ticks of continuous debounced press before key_long fires
//  PRESS_LEVEL  1'b1        raw input level meaning "pressed"
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  sys_rst      in   1       synchronous reset, active-high
//  button_in    in   N_KEYS  raw asynchronous buttons
//  key_level    out  N_KEYS  debounced state, 1 = pressed
//  key_press    out  N_KEYS  1-cycle pulse on debounced press
//  key_release  out  N_KEYS  1-cycle pulse on debounced release
//  key_long     out  N_KEYS  1-cycle pulse, once per hold, at LONG_MS
//  any_press    out  1       OR of key_press, same cycle
// BEHAVIOUR
//  - Reset (sys_rst=1 at a clk edge): all outputs 0, prescaler 0, all counters 0.
//    Sync flops and debounced state load the released level; reset mid-press discards the in-flight event.
//  - Sync: 2-FF synchroniser per key, normalised so 1 = pressed (XNOR with PRESS_LEVEL). Adds 2 cycles latency.
//  - Tick: prescaler counts 0..TICK_DIV-1 and wraps; tick=1 for one cycle when it equals TICK_DIV-1. The tick is shared by all keys.
//  - Per-key FSM, states REL, REL_CHK, PRS, PRS_CHK:
//      REL: s=1 -> REL_CHK, dcnt=0.
//      REL_CHK: s=0 -> REL, dcnt=0 (glitch rejected).
//        On tick with s=1: dcnt++; when the increment reaches DEBOUNCE_MS -> PRS, key_level=1, key_press pulse, hcnt=0.
//      PRS: s=0 -> PRS_CHK, dcnt=0.
//        On tick: hcnt++ (saturating); when hcnt reaches LONG_MS, key_long pulses exactly once.
//      PRS_CHK: s=1 -> PRS, dcnt=0 (hcnt keeps running).
//        On tick with s=0: dcnt++; when it reaches DEBOUNCE_MS -> REL, key_level=0, key_release pulse, hcnt=0.
//  - Pulse outputs are registered: asserted the cycle after the accepting tick edge, high for exactly 1 cycle.
//  - Press latency from a clean edge: 2 sync cycles + between (DEBOUNCE_MS-1)*TICK_DIV+1 and DEBOUNCE_MS*TICK_DIV cycles, +1 register.
//  - Counter widths: $clog2(TICK_DIV), $clog2(DEBOUNCE_MS+1), $clog2(LONG_MS+1). hcnt never wraps.
//  - Keys are independent; simultaneous events on several keys fire in the same cycle.
//  - key_long never fires if release is accepted before LONG_MS ticks.
//  - key_press and key_release are never both set for one key in the same cycle.
//  - The minimum accepted press or release width is DEBOUNCE_MS ticks.
//    Any bounce shorter than one tick window always resets dcnt.
// TESTING (bench params: CLK_FREQ_HZ=10_000 so TICK_DIV=10, DEBOUNCE_MS=4, LONG_MS=20)
//  1. Clean step on button_in[0] 0->1, held 100 cycles.
//     -> key_press[0] is one pulse 33..43 cycles after the edge; key_level[0]=1 afterwards; no other outputs.
//  2. button_in[1] toggles every 15 cycles for 200 cycles, then held at 1.
//     -> no pulse during bounce; exactly one key_press[1] after the stable hold; no key_release[1].
//  3. button_in[0] held 300 cycles.
//     -> exactly one key_long[0], 200+-10 cycles after key_press[0]; none afterwards.
//  4. Release after case 1 (held only 100 cycles).
//     -> one key_release[0] 33..43 cycles after the falling edge; key_level[0]=0; no key_long[0].
//  5. button_in 3'b000 -> 3'b101 in one cycle.
//     -> key_press[0] and key_press[2] in the same cycle, along with any_press.
//  6. sys_rst pulsed 1 cycle while key 2 is held and debounced.
//     -> all outputs 0 next cycle; with the key still held, a fresh key_press[2] follows within 43 cycles.

Source files
------------

// File: rtl/key_debounce_ctrl.sv
// key_debounce_ctrl: per-key synchroniser, tick-based debouncer and press/release/long-press pulse generator
module key_debounce_ctrl #(
    parameter int   N_KEYS      = 3,
    parameter int   CLK_FREQ_HZ = 50_000_000,
    parameter int   DEBOUNCE_MS = 20,
    parameter int   LONG_MS     = 1000,
    parameter logic PRESS_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic [N_KEYS-1:0] button_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic              any_press
);
    localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
    localparam int PW       = $clog2(TICK_DIV);
    localparam int DW       = $clog2(DEBOUNCE_MS + 1);
    localparam int HW       = $clog2(LONG_MS + 1);

    typedef enum logic [1:0] {REL, REL_CHK, PRS, PRS_CHK} state_t;

    logic [N_KEYS-1:0] sync1_q, sync2_q;
    logic [PW-1:0]     pre_q;
    logic              tick;

    assign tick      = pre_q == PW'(TICK_DIV - 1);
    assign any_press = |key_press;

    // two-flop synchroniser, stored normalised so that 1 means pressed
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ~(button_in ^ {N_KEYS{PRESS_LEVEL}});
            sync2_q <= sync1_q;
        end
    end

    // shared 1 ms prescaler, wraps at TICK_DIV-1
    always_ff @(posedge clk) begin
        if (sys_rst) pre_q <= '0;
        else         pre_q <= tick ? '0 : pre_q + 1'b1;
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        state_t        state_q, state_d;
        logic [DW-1:0] dcnt_q, dcnt_d, dinc;
        logic [HW-1:0] hcnt_q, hcnt_d;
        logic          press_q, press_d, release_q, release_d, long_q, long_d;
        logic          s, held;

        assign s    = sync2_q[k];
        assign held = state_q == PRS || state_q == PRS_CHK;
        assign dinc = dcnt_q + 1'b1;

        assign key_level[k]   = held;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;
        assign key_long[k]    = long_q;

        // debounce FSM: a change is accepted after DEBOUNCE_MS ticks of uninterrupted difference
        always_comb begin
            state_d   = state_q;
            dcnt_d    = dcnt_q;
            hcnt_d    = hcnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            long_d    = 1'b0;
            if (tick && held && hcnt_q != HW'(LONG_MS)) begin
                hcnt_d = hcnt_q + 1'b1;
                long_d = hcnt_q == HW'(LONG_MS - 1);
            end
            case (state_q)
                REL: begin
                    if (s) begin
                        state_d = REL_CHK;
                        dcnt_d  = '0;
                    end
                end
                REL_CHK: begin
                    if (!s) begin
                        state_d = REL;
                        dcnt_d  = '0;
                    end else if (tick) begin
                        dcnt_d = dinc;
                        if (dinc == DW'(DEBOUNCE_MS)) begin
                            state_d = PRS;
                            dcnt_d  = '0;
                            hcnt_d  = '0;
                            press_d = 1'b1;
                        end
                    end
                end
                PRS: begin
                    if (!s) begin
                        state_d = PRS_CHK;
                        dcnt_d  = '0;
                    end
                end
                default: begin
                    if (s) begin
                        state_d = PRS;
                        dcnt_d  = '0;
                    end else if (tick) begin
                        dcnt_d = dinc;
                        if (dinc == DW'(DEBOUNCE_MS)) begin
                            state_d   = REL;
                            dcnt_d    = '0;
                            hcnt_d    = '0;
                            release_d = 1'b1;
                        end
                    end
                end
            endcase
        end

        // per-key state, counters and registered event pulses
        always_ff @(posedge clk) begin
            if (sys_rst) begin
                state_q   <= REL;
                dcnt_q    <= '0;
                hcnt_q    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                dcnt_q    <= dcnt_d;
                hcnt_q    <= hcnt_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
            end
        end
    end
endmodule

// File: tb/tb_key_debounce_ctrl.sv
// tb_key_debounce_ctrl: scoreboard bench with a behavioural debounce model and randomized buttons
module tb_key_debounce_ctrl;
    localparam int N  = 3;
    localparam int TD = 10;
    localparam int DB = 4;
    localparam int LG = 20;

    typedef struct {
        int           cyc;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] lng;
        logic [N-1:0] lvl;
    } ev_t;

    logic         clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic [N-1:0] button_in = '0;
    logic [N-1:0] key_level, key_press, key_release, key_long;
    logic         any_press;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    ev_t q[$];

    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_prev = '0, m_lvl = '0;
    int m_run[N], m_hold[N];
    int m_age = 0;
    int n_press[N], n_rel[N], n_long[N], t_press[N], t_rel[N], t_long[N];

    key_debounce_ctrl #(
        .N_KEYS(N), .CLK_FREQ_HZ(10_000), .DEBOUNCE_MS(DB), .LONG_MS(LG), .PRESS_LEVEL(1'b1)
    ) dut (
        .clk(clk), .sys_rst(sys_rst), .button_in(button_in),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_long(key_long), .any_press(any_press)
    );

    always #5 clk = ~clk;

    // reference: a change counts ticks while the synced input has differed from the level
    // since at least the previous cycle; hold time counts ticks while the level is pressed
    always @(posedge clk) begin
        ev_t  e;
        logic tick, s;
        cyc++;
        e.cyc = cyc;
        e.press = '0;
        e.rel = '0;
        e.lng = '0;
        if (sys_rst) begin
            m_s1 = '0; m_s2 = '0; m_prev = '0; m_lvl = '0; m_age = 0;
            for (int k = 0; k < N; k++) begin
                m_run[k] = 0;
                m_hold[k] = 0;
            end
        end else begin
            tick = (m_age % TD) == TD - 1;
            for (int k = 0; k < N; k++) begin
                s = m_s2[k];
                if (tick && m_lvl[k]) begin
                    m_hold[k]++;
                    if (m_hold[k] == LG) e.lng[k] = 1'b1;
                end
                if (s == m_lvl[k]) m_run[k] = 0;
                else if (tick && m_prev[k] == s) begin
                    m_run[k]++;
                    if (m_run[k] == DB) begin
                        m_lvl[k] = s;
                        m_run[k] = 0;
                        m_hold[k] = 0;
                        if (s) e.press[k] = 1'b1;
                        else e.rel[k] = 1'b1;
                    end
                end
            end
            m_prev = m_s2;
            m_s2 = m_s1;
            m_s1 = button_in;
            m_age++;
        end
        e.lvl = m_lvl;
        if (|{e.press, e.rel, e.lng}) q.push_back(e);
    end

    // monitor: pops an expected event whenever the DUT shows a pulse
    always @(negedge clk) begin
        ev_t e;
        checks++;
        if (key_level !== m_lvl) begin
            errors++;
            $display("FAIL level cyc %0d got %b want %b", cyc, key_level, m_lvl);
        end
        if (|{key_press, key_release, key_long, any_press}) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL spurious cyc %0d got p=%b r=%b l=%b any=%b want none",
                         cyc, key_press, key_release, key_long, any_press);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.press !== key_press || e.rel !== key_release ||
                    e.lng !== key_long || any_press !== (|e.press)) begin
                    errors++;
                    $display("FAIL event got cyc %0d p=%b r=%b l=%b any=%b want cyc %0d p=%b r=%b l=%b",
                             cyc, key_press, key_release, key_long, any_press,
                             e.cyc, e.press, e.rel, e.lng);
                end
            end
            for (int k = 0; k < N; k++) begin
                if (key_press[k]) begin n_press[k]++; t_press[k] = cyc; end
                if (key_release[k]) begin n_rel[k]++; t_rel[k] = cyc; end
                if (key_long[k]) begin n_long[k]++; t_long[k] = cyc; end
            end
        end else if (q.size() != 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            e = q.pop_front();
            $display("FAIL missing got none want event at cyc %0d p=%b r=%b l=%b",
                     e.cyc, e.press, e.rel, e.lng);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    initial begin
        int t0, p0, p2, r;
        for (int k = 0; k < N; k++) begin
            n_press[k] = 0; n_rel[k] = 0; n_long[k] = 0;
            t_press[k] = 0; t_rel[k] = 0; t_long[k] = 0;
        end
        cycles(3);
        sys_rst = 1'b0;
        chk("reset_outputs", int'({key_level, key_press, key_release, key_long, any_press}), 0, 0);

        button_in[0] = 1'b1;
        t0 = cyc;
        cycles(100);
        chk("t1_press_count", n_press[0], 1, 1);
        chk("t1_press_latency", t_press[0] - t0, 33, 43);
        chk("t1_level", int'(key_level), 1, 1);
        chk("t1_no_long", n_long[0], 0, 0);

        button_in[0] = 1'b0;
        t0 = cyc;
        cycles(60);
        chk("t4_release_count", n_rel[0], 1, 1);
        chk("t4_release_latency", t_rel[0] - t0, 33, 43);
        chk("t4_no_long", n_long[0], 0, 0);

        for (int i = 0; i < 14; i++) begin
            button_in[1] = ~button_in[1];
            cycles(15);
        end
        chk("t2_no_press_in_bounce", n_press[1], 0, 0);
        button_in[1] = 1'b1;
        cycles(80);
        chk("t2_press_after_hold", n_press[1], 1, 1);
        chk("t2_no_release", n_rel[1], 0, 0);
        button_in[1] = 1'b0;
        cycles(60);

        button_in[0] = 1'b1;
        cycles(300);
        chk("t3_long_count", n_long[0], 1, 1);
        chk("t3_long_delay", t_long[0] - t_press[0], 190, 210);
        button_in[0] = 1'b0;
        cycles(60);
        chk("t3_long_once", n_long[0], 1, 1);

        p0 = n_press[0];
        p2 = n_press[2];
        button_in = 3'b101;
        cycles(60);
        chk("t5_press0", n_press[0] - p0, 1, 1);
        chk("t5_press2", n_press[2] - p2, 1, 1);
        chk("t5_same_cycle", t_press[0] - t_press[2], 0, 0);

        p2 = n_press[2];
        sys_rst = 1'b1;
        cycles(1);
        r = cyc;
        sys_rst = 1'b0;
        chk("t6_reset_outputs", int'({key_level, key_press, key_release, key_long, any_press}), 0, 0);
        cycles(45);
        chk("t6_fresh_press", n_press[2] - p2, 1, 1);
        chk("t6_press_latency", t_press[2] - r, 1, 43);

        for (int i = 0; i < 150; i++) begin
            button_in = N'($urandom);
            if ($urandom_range(0, 29) == 0) begin
                sys_rst = 1'b1;
                cycles(1);
                sys_rst = 1'b0;
            end
            cycles($urandom_range(0, 3) == 0 ? $urandom_range(150, 300) : $urandom_range(1, 60));
        end
        button_in = '0;
        cycles(100);
        chk("queue_drained", q.size(), 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
